// File: rtl/led7219_rx.sv
// led7219_rx: receives the MAX7219 serial stream (DIN/CS/CLK) and rebuilds the
// register state of a chain of NCHAIN cascaded devices.
`default_nettype none

module led7219_rx #(
  parameter int NCHAIN   = 4,
  parameter int CNT_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  leds_out,
  input  logic                  leds_cs,
  input  logic                  leds_clk,
  output logic [64*NCHAIN-1:0]  image,
  output logic [4*NCHAIN-1:0]   intensity,
  output logic [3*NCHAIN-1:0]   scan_limit,
  output logic [8*NCHAIN-1:0]   decode,
  output logic [NCHAIN-1:0]     shutdown_n,
  output logic [NCHAIN-1:0]     test,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam int SRW = 16*NCHAIN;
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(SRW);
  localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(SRW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  logic din_s1_q, din_s2_q;
  logic cs_s1_q, cs_s2_q, cs_prev_q;
  logic sck_s1_q, sck_s2_q, sck_prev_q;

  state_t                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [SRW-1:0]        sr_q;
  logic [64*NCHAIN-1:0]  image_q;
  logic [4*NCHAIN-1:0]   intensity_q;
  logic [3*NCHAIN-1:0]   scan_limit_q;
  logic [8*NCHAIN-1:0]   decode_q;
  logic [NCHAIN-1:0]     shutdown_n_q;
  logic [NCHAIN-1:0]     test_q;
  logic                  frame_valid_q;
  logic                  frame_err_q;

  logic w_cs_fall, w_cs_rise, w_sck_rise;
  logic unused_sr_hi;

  // cs syncs reset low so a cs already low at reset release is not seen as a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1_q   <= 1'b0;
      din_s2_q   <= 1'b0;
      cs_s1_q    <= 1'b0;
      cs_s2_q    <= 1'b0;
      cs_prev_q  <= 1'b0;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      din_s1_q   <= leds_out;
      din_s2_q   <= din_s1_q;
      cs_s1_q    <= leds_cs;
      cs_s2_q    <= cs_s1_q;
      cs_prev_q  <= cs_s2_q;
      sck_s1_q   <= leds_clk;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
    end
  end

  assign w_cs_fall  =  cs_prev_q & ~cs_s2_q;
  assign w_cs_rise  = ~cs_prev_q &  cs_s2_q;
  assign w_sck_rise =  sck_s2_q  & ~sck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sr_q          <= '0;
      image_q       <= '0;
      intensity_q   <= '0;
      scan_limit_q  <= '0;
      decode_q      <= '0;
      shutdown_n_q  <= '0;
      test_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_cs_fall) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_sck_rise && !cs_s2_q) begin
            sr_q <= {sr_q[SRW-2:0], din_s2_q};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
          end
          if (w_cs_rise) state_q <= LATCH;
        end
        LATCH: begin
          state_q <= IDLE;
          if (cnt_q == CNT_FULL) begin
            frame_valid_q <= 1'b1;
            for (int i = 0; i < NCHAIN; i++) begin
              for (int d = 1; d <= 8; d++) begin
                if (sr_q[16*i+8 +: 4] == 4'(d))
                  image_q[64*i + 8*(d-1) +: 8] <= sr_q[16*i +: 8];
              end
              case (sr_q[16*i+8 +: 4])
                4'h9: decode_q[8*i +: 8]     <= sr_q[16*i +: 8];
                4'hA: intensity_q[4*i +: 4]  <= sr_q[16*i +: 4];
                4'hB: scan_limit_q[3*i +: 3] <= sr_q[16*i +: 3];
                4'hC: shutdown_n_q[i]        <= sr_q[16*i];
                4'hF: test_q[i]              <= sr_q[16*i];
                default: ;
              endcase
            end
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // word[15:12] carries no register information
  assign unused_sr_hi = ^sr_q;

  assign image       = image_q;
  assign intensity   = intensity_q;
  assign scan_limit  = scan_limit_q;
  assign decode      = decode_q;
  assign shutdown_n  = shutdown_n_q;
  assign test        = test_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_led7219_rx.sv
// tb_led7219_rx: directed frames against a register model with an expectation queue.
`default_nettype none

module tb_led7219_rx;

  logic clk = 1'b0, rst_n = 1'b0;
  logic leds_out = 1'b0, leds_cs = 1'b1, leds_clk = 1'b0;
  logic [255:0] image;
  logic [15:0]  intensity;
  logic [11:0]  scan_limit;
  logic [31:0]  decode;
  logic [3:0]   shutdown_n, test;
  logic         frame_valid, frame_err;

  led7219_rx #(.NCHAIN(4), .CNT_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .leds_out(leds_out), .leds_cs(leds_cs), .leds_clk(leds_clk),
    .image(image), .intensity(intensity), .scan_limit(scan_limit), .decode(decode),
    .shutdown_n(shutdown_n), .test(test), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         err;
    logic [255:0] img;
    logic [15:0]  inten;
    logic [11:0]  scan;
    logic [31:0]  dec;
    logic [3:0]   shdn;
    logic [3:0]   tst;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input exp_t e);
    chk({tag, ".image"},      image,      e.img);
    chk({tag, ".intensity"},  intensity,  e.inten);
    chk({tag, ".scan_limit"}, scan_limit, e.scan);
    chk({tag, ".decode"},     decode,     e.dec);
    chk({tag, ".shutdown_n"}, shutdown_n, e.shdn);
    chk({tag, ".test"},       test,       e.tst);
  endtask

  task automatic model_apply(input logic [63:0] bits);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w;
      int a;
      w = bits[16*i +: 16];
      a = int'(w[11:8]);
      if (a >= 1 && a <= 8) m.img[64*i + 8*(a-1) +: 8] = w[7:0];
      else if (a == 9)  m.dec[8*i +: 8]   = w[7:0];
      else if (a == 10) m.inten[4*i +: 4] = w[3:0];
      else if (a == 11) m.scan[3*i +: 3]  = w[2:0];
      else if (a == 12) m.shdn[i]         = w[0];
      else if (a == 15) m.tst[i]          = w[0];
    end
  endtask

  task automatic send_bit(input logic b, input int half);
    @(negedge clk);
    leds_out = b;
    repeat (half) @(negedge clk);
    leds_clk = 1'b1;
    repeat (half) @(negedge clk);
    leds_clk = 1'b0;
  endtask

  // bits[63:48] is shifted first and ends up in device 3
  task automatic send_frame(input logic [63:0] bits, input int n, input int half);
    logic b;
    @(negedge clk);
    leds_cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i < 64) b = bits[63-i];
      else        b = 1'b0;
      send_bit(b, half);
    end
    repeat (3) @(negedge clk);
    leds_cs = 1'b1;
  endtask

  task automatic check_result(input string tag);
    int lat;
    exp_t e;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (frame_valid || frame_err) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".pulse_seen"}, 256'(lat != 0), 256'(1));
    if (q.size() == 0) begin
      chk({tag, ".queue"}, 256'(0), 256'(1));
      return;
    end
    e = q.pop_front();
    if (lat == 0) return;
    chk({tag, ".latency"},     256'(lat),         256'(4));
    chk({tag, ".frame_valid"}, 256'(frame_valid), 256'(!e.err));
    chk({tag, ".frame_err"},   256'(frame_err),   256'(e.err));
    chk_regs(tag, e);
    @(negedge clk);
    chk({tag, ".pulse_end"}, 256'({frame_valid, frame_err}), 256'(0));
  endtask

  task automatic run(input string tag, input logic [63:0] bits, input int n, input int half);
    exp_t e;
    if (n == 64) begin
      model_apply(bits);
      e = m;
      e.err = 1'b0;
    end else begin
      e = m;
      e.err = 1'b1;
    end
    q.push_back(e);
    send_frame(bits, n, half);
    check_result(tag);
  endtask

  task automatic count_pulses(input int cycles, inout int pulses);
    repeat (cycles) begin
      @(negedge clk);
      if (frame_valid || frame_err) pulses++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    m = '0;
    repeat (3) @(negedge clk);
    chk_regs("reset", m);
    chk("reset.pulses", 256'({frame_valid, frame_err}), 256'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run("t1", {16'h01AA, 16'h0155, 16'h01F0, 16'h010F}, 64, 4);
    chk("t1.dev3_d1", image[199:192], 256'(8'hAA));
    chk("t1.dev2_d1", image[135:128], 256'(8'h55));
    chk("t1.dev1_d1", image[71:64],   256'(8'hF0));
    chk("t1.dev0_d1", image[7:0],     256'(8'h0F));

    run("t2a", {4{16'h0C01}}, 64, 4);
    run("t2b", {4{16'h0A07}}, 64, 4);
    chk("t2.shutdown_n", 256'(shutdown_n), 256'(4'b1111));
    chk("t2.intensity",  256'(intensity),  256'(16'h7777));

    run("t3_63", 64'h0B05_0905_0301_0C00, 63, 4);
    run("t3_65", 64'h0B05_0905_0301_0C00, 65, 4);
    run("t3_0",  64'h0, 0, 4);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      leds_out = i[0];
      leds_clk = 1'b1;
      count_pulses(4, pulses);
      leds_clk = 1'b0;
      count_pulses(4, pulses);
    end
    chk("t4.idle_pulses", 256'(pulses), 256'(0));
    run("t4", {4{16'h0801}}, 64, 4);
    chk("t4.dev0_d8", image[63:56], 256'(8'h01));

    @(negedge clk);
    leds_cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 30; i++) send_bit(1'b1, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) send_bit(1'b1, 4);
    repeat (3) @(negedge clk);
    leds_cs = 1'b1;
    pulses = 0;
    count_pulses(12, pulses);
    chk("t5.pulses", 256'(pulses), 256'(0));
    chk_regs("t5.after_reset", m);
    run("t5b", {4{16'h0305}}, 64, 4);

    run("t6a", {16'h0000, 16'h0F01, 16'h0000, 16'h0000}, 64, 4);
    chk("t6a.test", 256'(test), 256'(4'b0100));
    run("t6b", {4{16'h0F00}}, 64, 2);
    run("t6c", {16'h0000, 16'h0F01, 16'h0000, 16'h0000}, 64, 2);
    chk("t6c.test", 256'(test), 256'(4'b0100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led7219_rx.md
Name: led7219_rx

Overview:
- Receives the MAX7219 serial interface (DIN/CS/CLK) that the LED-matrix debug driver transmits on exp2_17/16/15, and rebuilds the register state of a cascaded chain of MAX7219 devices.
- Serves as a synthesizable loopback checker and simulation monitor for the LED-matrix debug path.
- Exposes the decoded 8x8 image and the control registers of each device, plus a pulse for each frame and a pulse for each malformed frame.

Parameters:
- NCHAIN, 4, number of cascaded MAX7219 devices (4 devices = 256 LEDs).
- CNT_BITS, 10, width of the bit counter; must hold 16*NCHAIN+1.

Ports:
- clk  input  1  system clock (24 MHz)
- rst_n  input  1  asynchronous active-low reset
- leds_out  input  1  serial data (DIN), asynchronous to clk
- leds_cs  input  1  load/chip-select, active low, asynchronous
- leds_clk  input  1  serial clock, asynchronous
- image  output  64*NCHAIN  digit registers; device i, digit d (1..8) at bits [64*i+8*(d-1)+7 : 64*i+8*(d-1)]
- intensity  output  4*NCHAIN  reg 0xA[3:0] per device
- scan_limit  output  3*NCHAIN  reg 0xB[2:0] per device
- decode  output  8*NCHAIN  reg 0x9 per device
- shutdown_n  output  NCHAIN  reg 0xC[0] per device (0 = shutdown)
- test  output  NCHAIN  reg 0xF[0] per device
- frame_valid  output  1  one-cycle pulse when a well-formed frame is latched
- frame_err  output  1  one-cycle pulse when a malformed frame is discarded

Behaviour:
- Input synchronization:
  - leds_out, leds_cs and leds_clk each pass through a 2-FF synchronizer, followed by one edge-detect register.
  - clk must be at least 4x the leds_clk frequency. Data is sampled from the synchronized leds_out on the cycle the synchronized leds_clk rising edge is detected.
- Shift register:
  - Width 16*NCHAIN, shifted left with the new bit entering at bit 0 (MSB-first per word).
  - After a full frame, device i's word = sr[16*i+15 : 16*i]. Device 0 is nearest DIN and receives the last word shifted.
- Bit counter:
  - Width CNT_BITS; cleared on the cs falling edge; incremented per sampled bit.
  - Saturates at 16*NCHAIN+1.
- State machine:
  - IDLE: waits for a synchronized cs falling edge, then goes to SHIFT. If cs is low when reset releases, the module stays in IDLE until a high-to-low transition occurs; the partial frame is ignored.
  - SHIFT: samples bits on leds_clk rising edges. On a cs rising edge it goes to LATCH.
  - LATCH: one cycle, then back to IDLE.
    - If count == 16*NCHAIN, each device word is decoded: addr = word[11:8], data = word[7:0].
    - addr 1..8 writes digit addr.
    - 0x9 writes decode, 0xA intensity[3:0], 0xB scan_limit[2:0], 0xC shutdown_n = data[0], 0xF test = data[0].
    - addr 0x0, 0xD and 0xE are no-ops; word[15:12] is ignored.
    - frame_valid pulses on the cycle after LATCH, together with the register update.
    - Any other count (short, long or zero) makes no register change and pulses frame_err instead.
- leds_clk edges while cs is high are ignored and do not alter the shift register or the counter.
- Latency: a pin-level cs rising edge produces updated outputs and frame_valid 4 clk cycles later (2 sync + 1 edge + 1 latch).
- Reset (asynchronous, any time including mid-frame):
  - State = IDLE, counter and shift register = 0.
  - image = 0, intensity = 0, scan_limit = 0, decode = 0, shutdown_n = 0 (power-up shutdown), test = 0.
  - frame_valid = 0, frame_err = 0.
- frame_valid and frame_err are never asserted together. Each pulses for exactly one cycle per frame.

Test Plan:
1. NCHAIN=4. Shift four words 0x01AA, 0x0155, 0x01F0, 0x010F, the first shifted ending up at device 3. Then raise cs.
   - Required: image digit1 of devices 3/2/1/0 = AA/55/F0/0F.
   - Required: frame_valid pulses once, 4 cycles after cs rises.
2. Send 0x0C01 to all devices, then 0x0A07 to all devices.
   - Required: shutdown_n = 4'b1111, intensity = 16'h7777, image unchanged.
3. Send 63 bits, then raise cs.
   - Required: frame_err pulses once; all outputs unchanged.
   - Repeat with 65 bits and with 0 bits: same result.
4. Toggle leds_clk 10 times with cs high, then send a valid frame of 0x0801 to all devices.
   - Required: the frame latches correctly; digit8 = 01 on all devices.
5. Assert rst_n low after 30 bits of a frame, release it with cs still low, finish the frame, raise cs.
   - Required: no frame_valid, no frame_err, all outputs at reset values.
   - Then send a full valid frame: it latches normally.
6. Send 0x0F01 followed by 0x0000 no-op words.
   - Required: test = 1 only for the targeted device; no-op devices keep their registers.
   - Repeat with leds_clk at clk/4: same result.
